// File: rtl/chess_pkg.sv
// chess_pkg: shared types and constants for the key conditioner.
//   key_state_e   : per-channel FSM state (IDLE, PRESSED, REPEAT)
//   LEFT..RIGHT   : direction indices into the key vectors
//   DEF_*         : default timing in clock cycles (50 MHz system clock)
//   cnt_width()   : counter width helper, never returns less than 1
package chess_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } key_state_e;

    localparam int LEFT     = 0;
    localparam int UP       = 1;
    localparam int DOWN     = 2;
    localparam int RIGHT    = 3;
    localparam int NUM_DIRS = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one conditioned input channel.
//   2-flop synchroniser -> stability counter / stable level -> press FSM
//   -> registered one-cycle event.
// Optional feature: define KEY_REPEAT_EN to add the REPEAT state and its
// counter (only active when REPEAT_EN is also set for the instance).
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   raw_i   : raw asynchronous input
//   event_o : one-cycle pulse on press (and repeat); also on release when
//             EVENT_ON_RELEASE is set
module key_debounce
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY     = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = DEF_REPEAT_PERIOD,
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter bit REPEAT_EN        = 1'b1,
    parameter bit EVENT_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic event_o
);

    if (DEBOUNCE_CYCLES < 1 ||
        (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1))) begin : g_param_check
        $error("key_debounce: timing parameters must be at least 1");
    end

    localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Released level of the raw input; also the reset value of the sync chain.
    localparam logic              IDLE_LEVEL = ACTIVE_LOW;

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_e       state_q, state_d;
    logic             event_q, event_d;
    logic             pressed;

`ifdef KEY_REPEAT_EN
    localparam int               RPT_CYCLES = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
    localparam int               RPT_W      = cnt_width(RPT_CYCLES);
    localparam logic [RPT_W-1:0] DELAY_MAX  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_MAX = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    always_comb begin
        meta_d   = raw_i;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Any agreeing cycle clears the count, so only an unbroken run of
        // DEBOUNCE_CYCLES mismatches moves the stable level.
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pressed = (stable_q != IDLE_LEVEL);

    always_comb begin
        state_d = state_q;
        event_d = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESSED;
                    event_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = IDLE;
                    event_d = EVENT_ON_RELEASE;
                end
`ifdef KEY_REPEAT_EN
                else if (REPEAT_EN) begin
                    if (rpt_cnt_q == DELAY_MAX) begin
                        state_d = REPEAT;
                        event_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef KEY_REPEAT_EN
            REPEAT: begin
                // Release wins over a due repeat so no pulse follows a release.
                if (!pressed) begin
                    state_d = IDLE;
                    event_d = EVENT_ON_RELEASE;
                end else if (rpt_cnt_q == PERIOD_MAX) begin
                    event_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= IDLE_LEVEL;
            sync_q   <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            cnt_q    <= '0;
            state_q  <= IDLE;
            event_q  <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            event_q  <= event_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign event_o = event_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounces four active-low direction keys and one
// active-high slide switch into clean single-cycle events.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat on the four
// direction keys (the switch is never repeated).
// Ports:
//   Clock                                  : system clock
//   Reset                                  : asynchronous active-low reset
//   KeyLeft/KeyUp/KeyDown/KeyRight         : raw keys, active-low, async
//   Switch                                 : raw switch, active-high, async
//   LeftPulse/UpPulse/DownPulse/RightPulse : one-cycle press events
//   AnyPulse                               : OR of the direction events
//   SwitchLevel                            : debounced switch level
//   SwitchToggle                           : one-cycle pulse per level change
module key_conditioner
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KeyLeft,
    input  logic KeyUp,
    input  logic KeyDown,
    input  logic KeyRight,
    input  logic Switch,
    output logic LeftPulse,
    output logic UpPulse,
    output logic DownPulse,
    output logic RightPulse,
    output logic SwitchLevel,
    output logic SwitchToggle,
    output logic AnyPulse
);

    logic [NUM_DIRS-1:0] key_raw;
    logic [NUM_DIRS-1:0] key_pulse;
    logic                sw_toggle;
    logic                sw_level_q, sw_level_d;

    assign key_raw[LEFT]  = KeyLeft;
    assign key_raw[UP]    = KeyUp;
    assign key_raw[DOWN]  = KeyDown;
    assign key_raw[RIGHT] = KeyRight;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (1'b1),
            .REPEAT_EN       (1'b1),
            .EVENT_ON_RELEASE(1'b0)
        ) u_key (
            .clk    (Clock),
            .rst_n  (Reset),
            .raw_i  (key_raw[i]),
            .event_o(key_pulse[i])
        );
    end

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .ACTIVE_LOW      (1'b0),
        .REPEAT_EN       (1'b0),
        .EVENT_ON_RELEASE(1'b1)
    ) u_switch (
        .clk    (Clock),
        .rst_n  (Reset),
        .raw_i  (Switch),
        .event_o(sw_toggle)
    );

    // The switch channel emits an event on every debounced change, so the
    // level is the running parity of those events. Folding in the live
    // event makes SwitchLevel change on the same edge as SwitchToggle.
    always_comb begin
        sw_level_d = sw_level_q ^ sw_toggle;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sw_level_q <= 1'b0;
        end else begin
            sw_level_q <= sw_level_d;
        end
    end

    assign LeftPulse    = key_pulse[LEFT];
    assign UpPulse      = key_pulse[UP];
    assign DownPulse    = key_pulse[DOWN];
    assign RightPulse   = key_pulse[RIGHT];
    assign AnyPulse     = |key_pulse;
    assign SwitchToggle = sw_toggle;
    assign SwitchLevel  = sw_level_d;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed stimulus with a scoreboard of expected output
// events keyed by clock-edge number; every cycle all outputs are compared.
module tb_key_conditioner;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    // Event mask bits: {Left, Up, Down, Right, Any, SwitchToggle}
    localparam logic [5:0] M_L   = 6'b100010;
    localparam logic [5:0] M_U   = 6'b010010;
    localparam logic [5:0] M_D   = 6'b001010;
    localparam logic [5:0] M_R   = 6'b000110;
    localparam logic [5:0] M_DR  = 6'b001110;
    localparam logic [5:0] M_TOG = 6'b000001;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  mask;
    } ev_t;

    logic Clock = 1'b0;
    logic Reset, KeyLeft, KeyUp, KeyDown, KeyRight, Switch;
    logic LeftPulse, UpPulse, DownPulse, RightPulse;
    logic SwitchLevel, SwitchToggle, AnyPulse;

    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        mon_en   = 1'b0;
    logic        exp_lvl  = 1'b0;
    ev_t         sb[$];

    key_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .KeyLeft     (KeyLeft),
        .KeyUp       (KeyUp),
        .KeyDown     (KeyDown),
        .KeyRight    (KeyRight),
        .Switch      (Switch),
        .LeftPulse   (LeftPulse),
        .UpPulse     (UpPulse),
        .DownPulse   (DownPulse),
        .RightPulse  (RightPulse),
        .SwitchLevel (SwitchLevel),
        .SwitchToggle(SwitchToggle),
        .AnyPulse    (AnyPulse)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) edge_cnt <= edge_cnt + 1;

    // Advance n falling edges, then step off the edge before driving.
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    // Expect an event on edge k, where edge 0 is the next rising edge
    // (the first one that samples what was just driven).
    task automatic expect_ev(input int k, input logic [5:0] m);
        ev_t e;
        e.cyc  = edge_cnt + 1 + k;
        e.mask = m;
        sb.push_back(e);
    endtask

    // Monitor: compare all outputs after every rising edge.
    initial begin
        logic [5:0] exp_p;
        logic [6:0] obs;
        logic [6:0] expv;
        forever begin
            @(negedge Clock);
            if (mon_en) begin
                exp_p = '0;
                if (!Reset) exp_lvl = 1'b0;
                if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
                    exp_p = sb[0].mask;
                    void'(sb.pop_front());
                    if (exp_p[0]) exp_lvl = ~exp_lvl;
                end
                obs  = {LeftPulse, UpPulse, DownPulse, RightPulse, AnyPulse,
                        SwitchToggle, SwitchLevel};
                expv = {exp_p, exp_lvl};
                checks++;
                assert (obs === expv) else begin
                    errors++;
                    $error("FAIL outputs edge=%0d observed=%b expected=%b (L U D R Any Tog Lvl)",
                           edge_cnt, obs, expv);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; KeyLeft = 1'b1; KeyUp = 1'b1; KeyDown = 1'b1;
        KeyRight = 1'b1; Switch = 1'b0;
        #2 Reset = 1'b0;
        mon_en = 1'b1;
        wait_cyc(3);
        Reset = 1'b1;
        wait_cyc(8);

        // Single key press and release.
        KeyUp = 1'b0;
        expect_ev(DC + 2, M_U);
        wait_cyc(12);
        KeyUp = 1'b1;
        wait_cyc(10);

        // Bounce with 3-cycle runs never settles.
        for (int i = 0; i < 14; i++) begin
            KeyLeft = ~KeyLeft;
            wait_cyc(3);
        end
        KeyLeft = 1'b1;
        wait_cyc(10);

        // DEBOUNCE_CYCLES-1 low: rejected; exactly DEBOUNCE_CYCLES low: accepted.
        KeyDown = 1'b0;
        wait_cyc(DC - 1);
        KeyDown = 1'b1;
        wait_cyc(10);
        KeyDown = 1'b0;
        expect_ev(DC + 2, M_D);
        wait_cyc(DC);
        KeyDown = 1'b1;
        wait_cyc(12);

        // Simultaneous presses.
        KeyDown = 1'b0; KeyRight = 1'b0;
        expect_ev(DC + 2, M_DR);
        wait_cyc(10);
        KeyDown = 1'b1; KeyRight = 1'b1;
        wait_cyc(12);

        // Long hold of KeyRight, then release.
        KeyRight = 1'b0;
        expect_ev(6, M_R);
`ifdef KEY_REPEAT_EN
        expect_ev(26, M_R);
        expect_ev(34, M_R);
        expect_ev(42, M_R);
        expect_ev(50, M_R);
        expect_ev(58, M_R);
`endif
        wait_cyc(60);
        KeyRight = 1'b1;
        wait_cyc(20);

        // Reset mid-debounce with the key still held afterwards.
        KeyUp = 1'b0;
        wait_cyc(4);
        Reset = 1'b0;
        wait_cyc(3);
        Reset = 1'b1;
        expect_ev(DC + 2, M_U);
        wait_cyc(12);
        KeyUp = 1'b1;
        wait_cyc(12);

        // Reset during a long hold aborts any pending repeat.
        KeyLeft = 1'b0;
        expect_ev(6, M_L);
`ifdef KEY_REPEAT_EN
        expect_ev(26, M_L);
`endif
        wait_cyc(30);
        Reset = 1'b0;
        KeyLeft = 1'b1;
        wait_cyc(2);
        Reset = 1'b1;
        wait_cyc(40);

        // Switch up, switch down, then a short glitch.
        Switch = 1'b1;
        expect_ev(DC + 2, M_TOG);
        wait_cyc(12);
        Switch = 1'b0;
        expect_ev(DC + 2, M_TOG);
        wait_cyc(12);
        Switch = 1'b1;
        wait_cyc(2);
        Switch = 1'b0;
        wait_cyc(12);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
